// File: rtl/tx_sched_pkg.sv
// Shared state encoding and widths for the frame transmit scheduler.
// Pure declarations; no logic, no latency, no backpressure.
package tx_sched_pkg;

    localparam int SEG_W         = 16;
    localparam int ID_W          = 8;
    localparam int IFG_TICKS_DEF = 12;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO,
        GAP,
        NEXT,
        DONE,
        ABORT
    } sched_state_t;

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Scheduler <-> trigger/byte_data bundle; master is the scheduler side.
// Wires only; no latency; busy is the byte_data backpressure.
interface tx_frame_scheduler_if;
    import tx_sched_pkg::*;

    logic              enable;
    logic              frame_start;
    logic [2:0]        redundancy;
    logic              adv_data;
    logic              busy;
    logic              start_sending;
    logic [SEG_W-1:0]  segment_num;
    logic [ID_W-1:0]   txid;
    logic [7:0]        aux;
    logic              sched_active;
    logic              frame_done;
    logic [7:0]        overrun_cnt;
    logic [7:0]        timeout_cnt;

    modport master (
        input  enable, frame_start, redundancy, adv_data, busy,
        output start_sending, segment_num, txid, aux, sched_active,
               frame_done, overrun_cnt, timeout_cnt
    );

    modport slave (
        output enable, frame_start, redundancy, adv_data, busy,
        input  start_sending, segment_num, txid, aux, sched_active,
               frame_done, overrun_cnt, timeout_cnt
    );

endinterface

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at 255; count updates one clock after inc.
// No backpressure: every cycle with inc high is an event.
module sat_counter8 (
    input  logic       clk,
    input  logic       rstb,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Walks segments x copies of one frame, one start_sending pulse per packet, IFG in adv_data strobes.
// Packet rate is throttled by byte_data busy and the gap; enable is only honoured between packets.
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter int SEG_COUNT     = 720,
    parameter int IFG_TICKS     = IFG_TICKS_DEF,
    parameter int START_TIMEOUT = 255
) (
    input  logic                 clk125MHz,
    input  logic                 rstb,
    tx_frame_scheduler_if.master sif
);

    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEG_COUNT - 1);
    localparam logic [7:0]       IFG_LAST = 8'(IFG_TICKS - 1);
    localparam logic [7:0]       TO_LAST  = 8'(START_TIMEOUT - 1);

    sched_state_t state;
    logic [2:0]   red_latched;
    logic [7:0]   gap_cnt;
    logic [7:0]   to_cnt;
    logic         timeout_evt;
    logic         overrun_evt;

    assign timeout_evt = (state == WAIT_HI) && !sif.busy && (to_cnt == TO_LAST);
    assign overrun_evt = sif.frame_start && (state != IDLE);

    always_ff @(posedge clk125MHz or negedge rstb) begin
        if (!rstb) begin
            state             <= IDLE;
            red_latched       <= 3'd1;
            gap_cnt           <= 8'd0;
            to_cnt            <= 8'd0;
            sif.start_sending <= 1'b0;
            sif.segment_num   <= '0;
            sif.txid          <= '0;
            sif.aux           <= 8'd0;
            sif.sched_active  <= 1'b0;
            sif.frame_done    <= 1'b0;
        end else begin
            sif.start_sending <= 1'b0;
            sif.frame_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (sif.frame_start && sif.enable) begin
                        sif.sched_active <= 1'b1;
                        state            <= LOAD;
                    end
                end
                LOAD: begin
                    red_latched       <= (sif.redundancy == 3'd0) ? 3'd1 : sif.redundancy;
                    sif.segment_num   <= '0;
                    sif.aux           <= 8'd0;
                    sif.start_sending <= 1'b1;
                    state             <= START;
                end
                START: begin
                    to_cnt <= 8'd0;
                    state  <= WAIT_HI;
                end
                WAIT_HI: begin
                    // A launch byte_data never acknowledges still counts as sent.
                    if (sif.busy) begin
                        state <= WAIT_LO;
                    end else if (to_cnt == TO_LAST) begin
                        gap_cnt <= 8'd0;
                        state   <= GAP;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                WAIT_LO: begin
                    if (!sif.busy) begin
                        gap_cnt <= 8'd0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (sif.adv_data) begin
                        if (gap_cnt == IFG_LAST) begin
                            state <= sif.enable ? NEXT : ABORT;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                end
                NEXT: begin
                    if (sif.aux < ({5'd0, red_latched} - 8'd1)) begin
                        sif.aux           <= sif.aux + 8'd1;
                        sif.start_sending <= 1'b1;
                        state             <= START;
                    end else if (sif.segment_num < SEG_LAST) begin
                        sif.aux           <= 8'd0;
                        sif.segment_num   <= sif.segment_num + 1'b1;
                        sif.start_sending <= 1'b1;
                        state             <= START;
                    end else begin
                        sif.frame_done <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE, ABORT: begin
                    sif.txid         <= sif.txid + 1'b1;
                    sif.sched_active <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter8 u_overrun_cnt (
        .clk   (clk125MHz),
        .rstb  (rstb),
        .inc   (overrun_evt),
        .count (sif.overrun_cnt)
    );

    sat_counter8 u_timeout_cnt (
        .clk   (clk125MHz),
        .rstb  (rstb),
        .inc   (timeout_evt),
        .count (sif.timeout_cnt)
    );

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
Sequences transmission of one captured video frame as a series of Ethernet packets by driving the byte_data start/busy handshake. It walks segment numbers 0..SEG_COUNT-1, sends each segment `redundancy` times (copy index on aux), and enforces an inter-packet gap counted in adv_data byte-times. It runs in the clk125MHz domain, between the frame trigger and byte_data/tx_memory_control, which consume segment_num/txid/aux.

Parameters:
SEG_COUNT, 720, segments per frame (1..65535)
IFG_TICKS, 12, idle adv_data strobes between packets (1..255)
START_TIMEOUT, 255, clocks allowed from start_sending to busy rising (1..255)

Ports:
clk125MHz  in  1  system clock
rstb  in  1  reset, asynchronous, active-low
enable  in  1  scheduling permitted (tied to phy_ready)
frame_start  in  1  single-cycle request to send one frame
redundancy  in  3  copies per segment, 0 treated as 1
adv_data  in  1  byte-time strobe (speed-dependent)
busy  in  1  byte_data packet in progress
start_sending  out  1  single-cycle packet launch pulse
segment_num  out  16  current segment
txid  out  8  frame id
aux  out  8  copy index within segment (0..red-1)
sched_active  out  1  high from LOAD until return to IDLE
frame_done  out  1  single-cycle pulse, full frame sent
overrun_cnt  out  8  rejected frame_start count, saturating
timeout_cnt  out  8  start timeouts, saturating

Behaviour:
- Reset (rstb=0, async): state IDLE; all outputs 0; red_latched=1.
- All outputs are registered. segment_num/txid/aux change only in LOAD, NEXT, or DONE/ABORT, and never between a START pulse and busy falling.
- IDLE: frame_start=1 and enable=1 -> LOAD. frame_start with enable=0 is ignored, no count.
- LOAD (1 cycle): latch red = (redundancy==0 ? 1 : redundancy); segment_num=0; aux=0; sched_active=1 -> START.
- START (1 cycle): start_sending=1; clear timeout counter -> WAIT_HI.
- WAIT_HI: busy=1 -> WAIT_LO. After START_TIMEOUT clocks with busy=0: timeout_cnt+1 (saturate 255) -> GAP. The packet counts as sent; there is no retry.
- WAIT_LO: busy=0 -> GAP. There is no timeout here; byte_data owns the packet length.
- GAP: count IFG_TICKS adv_data strobes.
  - If the count completes and enable=0 -> ABORT.
  - If the count completes otherwise -> NEXT.
  - With adv_data stuck low (speed 2'b00), GAP holds indefinitely. This is intended.
- NEXT (1 cycle):
  - If aux < red-1: aux+1 -> START.
  - Else if segment_num < SEG_COUNT-1: aux=0, segment_num+1 -> START.
  - Else -> DONE.
- DONE (1 cycle): frame_done=1; txid+1 (255 wraps to 0) -> IDLE, sched_active=0.
- ABORT (1 cycle): txid+1, no frame_done -> IDLE. An in-flight packet is never cut: enable is only sampled in GAP.
- frame_start while sched_active=1: ignored; overrun_cnt+1 (saturate 255). A frame_start in the DONE/ABORT cycle is also rejected and counted.
- Earliest restart: frame_start is accepted the first cycle after IDLE is re-entered.
- redundancy changes mid-frame have no effect until the next LOAD.
- Minimum packet-to-packet spacing in clocks: START + WAIT_HI ≥1 + WAIT_LO + IFG strobes + NEXT.
- Width rules:
  - segment comparison uses a 16-bit unsigned compare against SEG_COUNT-1.
  - aux compare uses zero-extended red.

Decomposition:
- Shared package tx_sched_pkg holds:
  - state encoding: IDLE, LOAD, START, WAIT_HI, WAIT_LO, GAP, NEXT, DONE, ABORT;
  - widths SEG_W=16, ID_W=8;
  - default IFG_TICKS.
- One natural sub-module, sat_counter8: an 8-bit saturating event counter with async active-low reset. It is instantiated twice, for overrun_cnt and timeout_cnt.
- The FSM and gap/timeout counters live in the top module.

Test Plan:
- Basic frame: SEG_COUNT=3, red=1, busy model 20 clocks after start, adv_data every cycle, IFG_TICKS=12.
  - Expect 3 start pulses with segment_num 0,1,2 and aux=0.
  - Expect frame_done once, then txid 0->1.
  - Expect ≥12 clocks between busy fall and the next start.
- Redundancy: red=3, SEG_COUNT=2 -> 6 starts with (seg,aux) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). Repeat with red=0 -> 2 starts, aux=0.
- Timeout: byte_data model never raises busy, START_TIMEOUT=10, SEG_COUNT=2.
  - Expect 2 starts, each followed by 10 WAIT_HI clocks.
  - Expect timeout_cnt=2 and frame_done asserted.
- Overrun and saturation:
  - Pulse frame_start 5 times mid-frame -> overrun_cnt=5 and the frame is unaffected.
  - Pulse 300 times -> overrun_cnt stays at 255.
- Enable drop: deassert enable during packet (seg=1, aux=0), SEG_COUNT=4.
  - Expect that packet to complete busy normally, then GAP, then ABORT.
  - Expect no frame_done, txid+1, and no further start_sending.
- Async reset: assert rstb=0 in WAIT_LO mid-frame -> all outputs 0 immediately, without waiting for a clock edge. After release, frame_start restarts at seg 0 with txid=0.
